// File: rtl/avg_stream_param.sv
`default_nettype none
// ============================================================================
// Module   : avg_stream_param
// Brief    : Block averager. Sums LANES samples/beat over 2**LOG2_BEATS beats
//            through a registered adder tree and accumulator; emits sum and
//            power-of-two rounded (or truncated) average over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module avg_stream_param #(
  parameter  int DATA_W     = 8,
  parameter  int LANES      = 8,
  parameter  int LOG2_BEATS = 5,
  parameter  int ROUND      = 1,
  localparam int c_lvl      = $clog2(LANES),
  localparam int c_sh       = c_lvl + LOG2_BEATS,
  localparam int c_sum_w    = DATA_W + c_sh
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_avg,
  output logic [c_sum_w-1:0]      out_sum,
  output logic [LOG2_BEATS:0]     beat_cnt
);

  localparam int c_tree_w = DATA_W + c_lvl;
  localparam int c_dw     = $clog2(c_lvl + 1) + 1;
  localparam int c_sh_m1  = (c_sh > 0) ? c_sh - 1 : 0;

  localparam logic [LOG2_BEATS:0] c_last_beat  = (LOG2_BEATS + 1)'((1 << LOG2_BEATS) - 1);
  localparam logic [c_dw-1:0]     c_drain_last = c_dw'(c_lvl);
  localparam logic [c_sum_w:0]    c_half       =
      (ROUND != 0 && c_sh > 0) ? ((c_sum_w + 1)'(1) << c_sh_m1) : '0;

  localparam logic [1:0] c_st_accum = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_avg;
  logic [c_sum_w-1:0]  r_out_sum;
  logic [LOG2_BEATS:0] r_beat_cnt;
  logic [c_dw-1:0]     r_drain_cnt;
  logic [c_sum_w-1:0]  r_acc;
  logic [c_sum_w:0]    w_rnd;
  logic [DATA_W-1:0]   w_avg;
  logic                w_push;
  logic                w_release;
  logic                w_load;
  logic                w_in_ready_nxt;
  logic                w_out_valid_nxt;

  logic [c_tree_w-1:0] w_node [0:c_lvl][0:LANES-1];
  logic [c_lvl:0]      w_tv;

  assign w_push    = in_valid & r_in_ready & ~clear;
  assign w_release = (r_state == c_st_hold) & out_ready;
  assign w_tv[0]   = w_push;

  // Level 0 is the raw beat; each further level halves the node count and grows one bit.
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_node[0][k] = c_tree_w'(in_data[k*DATA_W +: DATA_W]);
    end

    for (genvar l = 1; l <= c_lvl; l++) begin : g_lvl
      logic r_v;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_v <= 1'b0;
        else if (clear) r_v <= 1'b0;
        else            r_v <= w_tv[l-1];
      end

      assign w_tv[l] = r_v;

      for (genvar k = 0; k < LANES; k++) begin : g_node
        if (k < (LANES >> l)) begin : g_reg
          localparam int c_w = DATA_W + l;
          logic [c_w-1:0] r_sum;

          always_ff @(posedge clk or negedge rst) begin
            if (!rst)
              r_sum <= '0;
            else if (w_tv[l-1])
              r_sum <= c_w'(w_node[l-1][2*k] + w_node[l-1][2*k+1]);
          end

          assign w_node[l][k] = c_tree_w'(r_sum);
        end else begin : g_pad
          assign w_node[l][k] = '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_acc <= '0;
    else if (clear || w_release)
      r_acc <= '0;
    else if (w_tv[c_lvl])
      r_acc <= r_acc + c_sum_w'(w_node[c_lvl][0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_beat_cnt <= '0;
    else if (clear || w_release)
      r_beat_cnt <= '0;
    else if (w_push)
      r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  // Counts the settle cycles the tree and accumulator need after the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_drain_cnt <= '0;
    else if (r_state == c_st_drain && !clear)
      r_drain_cnt <= r_drain_cnt + 1'b1;
    else
      r_drain_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_accum;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = c_st_accum;
    end else begin
      case (r_state)
        c_st_accum: if (w_push && r_beat_cnt == c_last_beat) w_state_nxt = c_st_drain;
        c_st_drain: if (r_drain_cnt == c_drain_last)         w_state_nxt = c_st_hold;
        c_st_hold:  if (out_ready)                           w_state_nxt = c_st_accum;
        default:                                             w_state_nxt = c_st_accum;
      endcase
    end
  end

  always_comb begin
    w_load          = (r_state == c_st_drain) && (w_state_nxt == c_st_hold);
    w_in_ready_nxt  = (w_state_nxt == c_st_accum);
    w_out_valid_nxt = (w_state_nxt == c_st_hold);
  end

  assign w_rnd = {1'b0, r_acc} + c_half;
  assign w_avg = DATA_W'(w_rnd >> c_sh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_avg   <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load) begin
        r_out_sum <= r_acc;
        r_out_avg <= w_avg;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_avg   = r_out_avg;
  assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire
